// File: rtl/apb_pkg.sv
// Shared types and constants for the APB responder.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 20;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned WAIT_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_resp_state_e;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/apb_responder_if.sv
// APB3 bus signals between an initiator and a completer.
interface apb_responder_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH = APB_DATA_W
);
    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, paddr, pwdata, pwrite,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwdata, pwrite,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_resp_mem.sv
// Word register bank: flop array, async clear, one write port, async read port.
module apb_resp_mem #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rd_data_c
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Bank storage, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_data_c = mem_q[raddr_i];
endmodule

// File: rtl/apb_responder.sv
// APB3 completer model: register bank, programmable wait states, error flagging, statistics.
module apb_responder
    import apb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = APB_ADDR_W,
    parameter int unsigned           DATA_WIDTH = APB_DATA_W,
    parameter int unsigned           DEPTH_LOG2 = 6,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic               clk,
    input  logic               reset,
    apb_responder_if.slave     apb,
    input  logic [WAIT_W-1:0]  cfg_wait,
    input  logic               cfg_err_inject,
    output logic [CNT_W-1:0]   wr_count,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   abort_count
);
    // Bank window is aligned, so range decode is a compare of the upper address bits.
    localparam int unsigned HI_LSB = DEPTH_LOG2 + 2;

    apb_resp_state_e       state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  bad_q, bad_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]      abort_cnt_q, abort_cnt_d;

    logic                  misalign_c;
    logic                  in_range_c;
    logic                  bad_c;
    logic [DEPTH_LOG2-1:0] raddr_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic                  mem_we_c;

    // Setup-phase decode of the live address.
    assign misalign_c = (apb.paddr[1:0] != 2'b00);
    assign in_range_c = (apb.paddr[ADDR_WIDTH-1:HI_LSB] == BASE_ADDR[ADDR_WIDTH-1:HI_LSB]);
    assign bad_c      = misalign_c | ~in_range_c | cfg_err_inject;

    // Zero-wait reads look up the live address; later ones use the latched word.
    assign raddr_c = (state_q == IDLE) ? apb.paddr[HI_LSB-1:2] : word_q;

    apb_resp_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .we_i      (mem_we_c),
        .waddr_i   (word_q),
        .wdata_i   (wdata_q),
        .raddr_i   (raddr_c),
        .rd_data_c (rd_data_c)
    );

    // State, transfer context, outputs and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            bad_q       <= 1'b0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            bad_q       <= bad_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    // Transfer FSM: setup capture, wait countdown, single-cycle completion, abort.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        bad_d       = bad_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = '0;
        mem_we_c    = 1'b0;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        abort_cnt_d = abort_cnt_q;

        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    word_d  = apb.paddr[HI_LSB-1:2];
                    wdata_d = apb.pwdata;
                    wr_d    = apb.pwrite;
                    bad_d   = bad_c;
                    cnt_d   = cfg_wait;
                    if (cfg_wait == '0) begin
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = bad_c;
                        prdata_d  = (!bad_c && !apb.pwrite) ? rd_data_c : '0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!apb.psel) begin
                    state_d     = IDLE;
                    abort_cnt_d = sat_inc(abort_cnt_q);
                end else if (apb.penable) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                    if (cnt_q == WAIT_W'(1)) begin
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = bad_q;
                        prdata_d  = (!bad_q && !wr_q) ? rd_data_c : '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!apb.psel) begin
                    abort_cnt_d = sat_inc(abort_cnt_q);
                end else begin
                    mem_we_c = !bad_q && wr_q;
                    if (bad_q) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else if (wr_q) begin
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end else begin
                        rd_cnt_d = sat_inc(rd_cnt_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign apb.pready   = pready_q;
    assign apb.pslverr  = pslverr_q;
    assign apb.prdata   = prdata_q;
    assign wr_count     = wr_cnt_q;
    assign rd_count     = rd_cnt_q;
    assign err_count    = err_cnt_q;
    assign abort_count  = abort_cnt_q;
endmodule
